// File: rtl/cga_arb_pkg.sv
// Shared state encoding and VRAM geometry for the CGA VRAM arbiter.
package cga_arb_pkg;

    localparam int VRAM_AW = 15;
    localparam int VRAM_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PEND,
        ST_ACCESS,
        ST_WAITD,
        ST_DONE
    } arb_state_e;

endpackage

// File: rtl/cga_bus_sync.sv
// Two-flop synchroniser for the async ISA memory strobes plus a falling-edge
// detect on "any strobe active". Strobe flops reset to the inactive (high) level.
module cga_bus_sync (
    input  logic clk,
    input  logic reset,
    input  logic memr_l_i,
    input  logic memw_l_i,
    output logic wr_act_o,
    output logic fall_o,
    output logic idle_o
);

    logic [1:0] rd_sync_q;
    logic [1:0] wr_sync_q;
    logic       act_prev_q;
    logic       act;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_sync_q  <= 2'b11;
            wr_sync_q  <= 2'b11;
            act_prev_q <= 1'b0;
        end else begin
            rd_sync_q  <= {rd_sync_q[0], memr_l_i};
            wr_sync_q  <= {wr_sync_q[0], memw_l_i};
            act_prev_q <= act;
        end
    end

    assign wr_act_o = ~wr_sync_q[1];
    assign act      = ~rd_sync_q[1] | ~wr_sync_q[1];
    assign fall_o   = act & ~act_prev_q;
    assign idle_o   = ~act;

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares the single VRAM port between display fetches and ISA CPU accesses.
// Define CGA_SNOW_EN to let CPU accesses steal display slots ("snow"); default build never does.
module cga_vram_arbiter
    import cga_arb_pkg::*;
#(
    parameter int USE_BUS_WAIT = 1,
    parameter int RAM_LATENCY  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               isa_slot,
    input  logic               disp_fetch,
    input  logic [VRAM_AW-1:0] disp_addr,
    input  logic               bus_memr_l,
    input  logic               bus_memw_l,
    input  logic               cpu_sel,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [VRAM_DW-1:0] cpu_wdata,
    output logic [VRAM_DW-1:0] cpu_rdata,
    output logic               bus_rdy,
    output logic [VRAM_AW-1:0] ram_a,
    output logic               ram_we_l,
    output logic [VRAM_DW-1:0] ram_dout,
    input  logic [VRAM_DW-1:0] ram_din,
    output logic [VRAM_DW-1:0] disp_data,
    output logic               snow
);

    localparam logic [1:0] LAT_LAST = 2'(RAM_LATENCY - 1);

    arb_state_e         state_q, state_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic [VRAM_DW-1:0] wdata_q, wdata_d;
    logic               wr_q, wr_d;
    logic [1:0]         lat_cnt_q, lat_cnt_d;
    logic [VRAM_DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic               wait_req;
    logic               grant_ok;

    logic               wr_act;
    logic               req_fall;
    logic               strobe_idle;

    logic [RAM_LATENCY-1:0] fetch_vld_q;
    logic [RAM_LATENCY-1:0] snow_vld_q;
    logic                   fetch_in;
    logic                   snow_in;
    logic                   in_access;
    logic [VRAM_DW-1:0]     snow_byte_q;
    logic                   snow_wr_q;
    logic [VRAM_DW-1:0]     disp_data_q;
    logic                   snow_q;

    cga_bus_sync u_sync (
        .clk      (clk),
        .reset    (reset),
        .memr_l_i (bus_memr_l),
        .memw_l_i (bus_memw_l),
        .wr_act_o (wr_act),
        .fall_o   (req_fall),
        .idle_o   (strobe_idle)
    );

`ifdef CGA_SNOW_EN
    assign grant_ok = 1'b1;
    assign fetch_in = disp_fetch;
    assign snow_in  = disp_fetch & in_access;
`else
    assign grant_ok = ~disp_fetch;
    assign fetch_in = disp_fetch & ~in_access;
    assign snow_in  = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_d        = wr_q;
        lat_cnt_d   = lat_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        wait_req    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Write strobe wins when both strobes fall together.
                if (req_fall && cpu_sel) begin
                    state_d  = ST_PEND;
                    addr_d   = cpu_addr;
                    wdata_d  = cpu_wdata;
                    wr_d     = wr_act;
                    wait_req = 1'b1;
                end
            end
            ST_PEND: begin
                if (strobe_idle) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_req = 1'b1;
                    if (isa_slot && grant_ok) state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                wait_req  = 1'b1;
                lat_cnt_d = 2'd0;
                state_d   = wr_q ? ST_DONE : ST_WAITD;
            end
            ST_WAITD: begin
                wait_req = 1'b1;
                if (lat_cnt_q == LAT_LAST) begin
                    cpu_rdata_d = ram_din;
                    state_d     = ST_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            ST_DONE: begin
                if (strobe_idle) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            lat_cnt_q   <= 2'd0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            lat_cnt_q   <= lat_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        if (in_access) begin
            snow_byte_q <= wdata_q;
            snow_wr_q   <= wr_q;
        end
    end

    assign in_access = (state_q == ST_ACCESS);
    assign ram_a     = in_access ? addr_q : disp_addr;
    assign ram_we_l  = ~(in_access & wr_q);
    assign ram_dout  = wdata_q;
    assign bus_rdy   = (USE_BUS_WAIT != 0) ? ~wait_req : 1'b1;
    assign cpu_rdata = cpu_rdata_q;

    // Fetch tracking: a byte requested in cycle T lands in disp_data at T+RAM_LATENCY+1.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_vld_q <= '0;
            snow_vld_q  <= '0;
            disp_data_q <= '0;
            snow_q      <= 1'b0;
        end else begin
            fetch_vld_q[0] <= fetch_in;
            snow_vld_q[0]  <= snow_in;
            for (int i = 1; i < RAM_LATENCY; i++) begin
                fetch_vld_q[i] <= fetch_vld_q[i-1];
                snow_vld_q[i]  <= snow_vld_q[i-1];
            end
            snow_q <= snow_vld_q[RAM_LATENCY-1];
            if (snow_vld_q[RAM_LATENCY-1])
                disp_data_q <= snow_wr_q ? snow_byte_q : ram_din;
            else if (fetch_vld_q[RAM_LATENCY-1])
                disp_data_q <= ram_din;
        end
    end

    assign disp_data = disp_data_q;
    assign snow      = snow_q;

endmodule
